// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//
// Execute-stage wrapper that sits between decode and writeback, around an
// external combinational 32-bit ALU.
//
//   decode --(in_valid/in_ready)--> [issue reg] --> ALU --> [output reg]
//                                                       --(out_valid/out_ready)--> writeback
//
// The issue register drives the ALU. The output register captures the ALU
// result behind a valid/ready handshake. This block owns the architectural
// flags register, which feeds the ALU flags input.
//
// Parameters:
//   RD_W         destination register index width
//   FLAGS_RESET  flags register value after reset
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   in_valid/in_ready          decode handshake
//   in_op/in_a/in_b            opcode and operands
//   in_rd/in_wr_en             destination register and write enable
//   in_flags_we                commit ALU flags when the op executes
//   flush                      kill the op held in the issue register
//   flags_load_en/_val         direct flags write (restore path)
//   alu_a/alu_b/alu_op         to ALU, straight from the issue register
//   alu_flags_in               to ALU, equal to flags_q
//   alu_result/alu_flags       from ALU
//   out_valid/out_ready        writeback handshake
//   out_result/out_rd/out_wr_en registered result
//   flags_q                    architectural flags: bit0 C, bit1 Z, bit2 N, bit3 V
//
// Optional feature (macro ALU_EXEC_STAGE_PERF_EN):
//   perf_issued  counts issue-to-output advances
//   perf_stall   counts cycles an op waits in the issue register on a full
//                output register
//   Both counters wrap at 2^32 and clear on rst.
// -----------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int unsigned RD_W        = 5,
  parameter logic [7:0]  FLAGS_RESET = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  // decode side
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_op,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wr_en,
  input  logic            in_flags_we,
  input  logic            flush,
  input  logic            flags_load_en,
  input  logic [7:0]      flags_load_val,
  // ALU side
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [5:0]      alu_op,
  output logic [7:0]      alu_flags_in,
  input  logic [31:0]     alu_result,
  input  logic [7:0]      alu_flags,
  // writeback side
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wr_en,
  output logic [7:0]      flags_q
`ifdef ALU_EXEC_STAGE_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_stall
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [5:0]      op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [RD_W-1:0] rd;
    logic            wr_en;
    logic            flags_we;
  } iss_t;

  typedef struct packed {
    logic [31:0]     result;
    logic [RD_W-1:0] rd;
    logic            wr_en;
  } res_t;

  logic       iss_valid_q, iss_valid_d;
  iss_t       iss_q,       iss_d;
  logic       out_valid_q, out_valid_d;
  res_t       res_q,       res_d;
  logic [7:0] flags_d;
  logic [7:0] flags_r;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic out_free;
  logic adv;
  logic accept;

  // The output register can take a new result if it is empty or being drained.
  assign out_free = !out_valid_q || out_ready;
  // The op in the issue register moves on unless flush kills it this cycle.
  assign adv      = iss_valid_q && out_free && !flush;
  // in_ready depends on state, out_ready and flush only, never on in_valid,
  // so decode may wait for in_ready before raising in_valid without a loop.
  assign in_ready = !flush && (!iss_valid_q || adv);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its hold value first so that no path through the
    // branches below leaves it unassigned, which would infer a latch.
    iss_valid_d = iss_valid_q;
    iss_d       = iss_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    flags_d     = flags_r;

    // Issue register. Payload loads only on accept; while idle it keeps the
    // last op so the ALU inputs do not toggle needlessly.
    if (accept) begin
      iss_valid_d    = 1'b1;
      iss_d.op       = in_op;
      iss_d.a        = in_a;
      iss_d.b        = in_b;
      iss_d.rd       = in_rd;
      iss_d.wr_en    = in_wr_en;
      iss_d.flags_we = in_flags_we;
    end else if (adv || flush) begin
      iss_valid_d = 1'b0;
    end

    // Output register. Holds stable while valid and not drained.
    if (adv) begin
      out_valid_d  = 1'b1;
      res_d.result = alu_result;
      res_d.rd     = iss_q.rd;
      res_d.wr_en  = iss_q.wr_en;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Flags. The op in the issue register reads flags_r; its predecessor
    // committed on the edge this op entered, so there is no flags hazard.
    // The restore path wins over an ALU commit on the same edge.
    if (flags_load_en) begin
      flags_d = flags_load_val;
    end else if (adv && iss_q.flags_we) begin
      flags_d = alu_flags;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    if (rst) begin
      // NOTE: the datapath registers are reset as well, not just the valid
      // bits, because the ALU inputs and result outputs must read 0 after reset.
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_r     <= FLAGS_RESET;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_q       <= iss_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      flags_r     <= flags_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef ALU_EXEC_STAGE_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q,  perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (adv) begin
      perf_issued_d = perf_issued_q + 32'd1;
    end
    // A flushed op still counts as stalled if the output register is full.
    if (iss_valid_q && !out_free) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_a        = iss_q.a;
  assign alu_b        = iss_q.b;
  assign alu_op       = iss_q.op;
  assign alu_flags_in = flags_r;
  assign flags_q      = flags_r;

  assign out_valid    = out_valid_q;
  assign out_result   = res_q.result;
  assign out_rd       = res_q.rd;
  assign out_wr_en    = res_q.wr_en;

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Bench for alu_exec_stage. Supplies a behavioural ALU on the ALU ports and
// checks results with a scoreboard: every accepted op that must produce a
// result is evaluated in program order against a model flags value and its
// expected output is queued; a monitor pops and compares on every output
// handshake. Directed sequences cover latency, carry chaining, backpressure,
// flush, flags-load priority and mid-flight reset; a random phase follows.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

  localparam int         RD_W = 5;
  localparam logic [7:0] FRST = 8'h00;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_ADC = 6'h01;
  localparam logic [5:0] OP_SUB = 6'h02;
  localparam logic [5:0] OP_XOR = 6'h06;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      in_op;
  logic [31:0]     in_a;
  logic [31:0]     in_b;
  logic [RD_W-1:0] in_rd;
  logic            in_wr_en;
  logic            in_flags_we;
  logic            flush;
  logic            flags_load_en;
  logic [7:0]      flags_load_val;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [5:0]      alu_op;
  logic [7:0]      alu_flags_in;
  logic [31:0]     alu_result;
  logic [7:0]      alu_flags;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_result;
  logic [RD_W-1:0] out_rd;
  logic            out_wr_en;
  logic [7:0]      flags_q;
`ifdef ALU_EXEC_STAGE_PERF_EN
  logic [31:0]     perf_issued;
  logic [31:0]     perf_stall;
`endif

  alu_exec_stage #(.RD_W(RD_W), .FLAGS_RESET(FRST)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_rd          (in_rd),
    .in_wr_en       (in_wr_en),
    .in_flags_we    (in_flags_we),
    .flush          (flush),
    .flags_load_en  (flags_load_en),
    .flags_load_val (flags_load_val),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .alu_flags_in   (alu_flags_in),
    .alu_result     (alu_result),
    .alu_flags      (alu_flags),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_wr_en      (out_wr_en),
    .flags_q        (flags_q)
`ifdef ALU_EXEC_STAGE_PERF_EN
    ,
    .perf_issued    (perf_issued),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural ALU: returns {flags, result}. C is carry out (no-borrow for
  // subtract), V signed overflow; logic ops keep C and V. Opcodes above 6'h11
  // are undefined and return 0.
  // ---------------------------------------------------------------------------
  function automatic logic [39:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [7:0] fi);
    logic [32:0] w;
    logic [31:0] r;
    logic        c;
    logic        v;
    c = fi[0];
    v = fi[3];
    r = '0;
    w = '0;
    case (op)
      6'h00, 6'h01: begin
        w = {1'b0, a} + {1'b0, b} + ((op == 6'h01) ? {32'd0, fi[0]} : 33'd0);
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      6'h02, 6'h03: begin
        w = {1'b0, a} + {1'b0, ~b} + ((op == 6'h03) ? {32'd0, fi[0]} : 33'd1);
        r = w[31:0];
        c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      6'h04: r = a & b;
      6'h05: r = a | b;
      6'h06: r = a ^ b;
      6'h07: r = b;
      6'h08: r = ~a;
      6'h09: r = a << b[4:0];
      6'h0A: r = a >> b[4:0];
      6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h11: r = {a[15:0], b[15:0]};
      default: r = '0;
    endcase
    return {fi[7:4], v, r[31], (r == 32'd0), c, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_op, alu_a, alu_b, alu_flags_in);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0]     result;
    logic [RD_W-1:0] rd;
    logic            wr_en;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mflags;      // program-order flags state
  int         total = 0;
  int         bad   = 0;
  int         delivered = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Ops execute in program order; each sees the flags left by the previous
  // flag-writing op.
  task automatic model_push(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [RD_W-1:0] rd, input logic we, input logic fwe);
    logic [39:0] r;
    r = alu_fn(op, a, b, mflags);
    exp_q.push_back('{result: r[31:0], rd: rd, wr_en: we});
    if (fwe) mflags = r[39:32];
  endtask

  // Monitor: compares on each output handshake and checks the output register
  // holds while stalled.
  exp_t        mon_e;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_res  = '0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_result", {32'd0, out_result}, {32'd0, stall_res});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got result=%0h expected no output", out_result);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", {32'd0, out_result}, {32'd0, mon_e.result});
          check("out_rd", {59'd0, out_rd}, {59'd0, mon_e.rd});
          check("out_wr_en", {63'd0, out_wr_en}, {63'd0, mon_e.wr_en});
          delivered++;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_res  = out_result;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [RD_W-1:0] rd, input logic we, input logic fwe,
                      input bit expect_out);
    bit done;
    done        = 1'b0;
    in_valid    = 1'b1;
    in_op       = op;
    in_a        = a;
    in_b        = b;
    in_rd       = rd;
    in_wr_en    = we;
    in_flags_we = fwe;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        if (expect_out) model_push(op, a, b, rd, we, fwe);
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  // One backpressure cycle: offers op k (ADD k+1, 10*k) while k < 4.
  task automatic bp_cycle(inout int k);
    in_valid    = (k < 4);
    in_op       = OP_ADD;
    in_a        = 32'(k + 1);
    in_b        = 32'(10 * k);
    in_rd       = 5'(k + 8);
    in_wr_en    = 1'b1;
    in_flags_we = 1'b1;
    @(negedge clk);
    if (in_valid && in_ready) begin
      model_push(in_op, in_a, in_b, in_rd, in_wr_en, in_flags_we);
      k++;
    end
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    repeat (2) tick();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int          k;
    logic [5:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    rst            = 1'b1;
    in_valid       = 1'b0;
    in_op          = '0;
    in_a           = '0;
    in_b           = '0;
    in_rd          = '0;
    in_wr_en       = 1'b0;
    in_flags_we    = 1'b0;
    flush          = 1'b0;
    flags_load_en  = 1'b0;
    flags_load_val = '0;
    out_ready      = 1'b1;
    mflags         = FRST;

    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_flags", {56'd0, flags_q}, {56'd0, FRST});
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_alu_op", {58'd0, alu_op}, 64'd0);
    check("rst_alu_a", {32'd0, alu_a}, 64'd0);
    check("rst_alu_b", {32'd0, alu_b}, 64'd0);
    tick();

    // Single op: ADD 5+7, result valid in the cycle after edge E+1
    send(OP_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("lat_not_yet", {63'd0, out_valid}, 64'd0);
    tick();
    @(negedge clk);
    check("lat_valid", {63'd0, out_valid}, 64'd1);
    check("lat_result", {32'd0, out_result}, 64'd12);
    check("single_flags", {56'd0, flags_q}, 64'h00);
    tick();

    // Carry chain: ADD FFFFFFFF+1 then ADC 0+0 back-to-back
    send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1, 1'b1, 1'b1);
    send(OP_ADC, 32'd0, 32'd0, 5'd5, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("carry_flags_add", {56'd0, flags_q}, 64'h03);
    tick();
    @(negedge clk);
    check("carry_adc_result", {32'd0, out_result}, 64'd1);
    check("carry_flags_adc", {56'd0, flags_q}, 64'h00);
    tick();
    drain("carry_drain");

    // Backpressure: 5 cycles of out_ready=0 while offering 4 ADDs
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      bp_cycle(k);
      if (c == 4) check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      tick();
    end
    check("bp_accepted", 64'(k), 64'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (k < 4 || exp_q.size() > 0); c++) begin
      bp_cycle(k);
      tick();
    end
    check("bp_all_accepted", 64'(k), 64'd4);
    drain("bp_drain");

    // Flush: SUB 10-3 killed in the issue register; flags untouched
    out_ready = 1'b0;
    send(OP_SUB, 32'd10, 32'd3, 5'd6, 1'b1, 1'b1, 1'b0);
    flush       = 1'b1;
    in_valid    = 1'b1;
    in_op       = OP_ADD;
    in_a        = 32'd1;
    in_b        = 32'd1;
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_flags", {56'd0, flags_q}, {56'd0, mflags});
    tick();

    // Priority: flags load on the same edge as the ADD 0+0 commit
    send(OP_ADD, 32'd0, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1);
    flags_load_en  = 1'b1;
    flags_load_val = 8'h08;
    tick();
    flags_load_en  = 1'b0;
    mflags         = 8'h08;
    @(negedge clk);
    check("prio_flags", {56'd0, flags_q}, 64'h08);
    tick();
    drain("prio_drain");

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      r_op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(18, 63)) : 6'($urandom_range(0, 17));
      r_a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      in_valid    = ($urandom_range(0, 9) < 7);
      in_op       = r_op;
      in_a        = r_a;
      in_b        = r_b;
      in_rd       = 5'($urandom_range(0, 31));
      in_wr_en    = 1'($urandom_range(0, 1));
      in_flags_we = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (in_valid && in_ready) model_push(in_op, in_a, in_b, in_rd, in_wr_en, in_flags_we);
      tick();
    end
    drain("rand_drain");
    @(negedge clk);
    check("rand_flags", {56'd0, flags_q}, {56'd0, mflags});
`ifdef ALU_EXEC_STAGE_PERF_EN
    check("perf_issued", {32'd0, perf_issued}, 64'(delivered));
`endif
    tick();

    // Reset mid-flight: output and issue registers both full, flags nonzero
    out_ready = 1'b0;
    send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 5'd9, 1'b1, 1'b1, 1'b1);
    send(OP_SUB, 32'd2, 32'd3, 5'd10, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("mid_out_valid", {63'd0, out_valid}, 64'd1);
    check("mid_flags", {56'd0, flags_q}, 64'h03);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    mflags    = FRST;
    delivered = 0;
    @(negedge clk);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_flags", {56'd0, flags_q}, {56'd0, FRST});
    check("mid_rst_alu_op", {58'd0, alu_op}, 64'd0);
    check("mid_rst_alu_a", {32'd0, alu_a}, 64'd0);
    check("mid_rst_out_wr_en", {63'd0, out_wr_en}, 64'd0);
`ifdef ALU_EXEC_STAGE_PERF_EN
    check("mid_rst_perf_issued", {32'd0, perf_issued}, 64'd0);
    check("mid_rst_perf_stall", {32'd0, perf_stall}, 64'd0);
`endif
    tick();

    // Stage is usable again after reset
    out_ready = 1'b1;
    send(OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 5'd11, 1'b1, 1'b1, 1'b1);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
